// File: rtl/sqrt_unit_scheduler_if.sv
// Requester-side bundle for the shared square-root scheduler: request/grant and response/accept.
// Latency: none, wires only; grant is combinational and the response is registered inside the scheduler.
// Backpressure: req_ready_o grants one requester per op; rsp_valid_o holds until rsp_ready_i of the winner.
interface sqrt_unit_scheduler_if #(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_radicand_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [NUM_REQ-1:0]            rsp_ready_i;
    logic [DATA_WIDTH/2-1:0]       rsp_root_o;
    logic [DATA_WIDTH/2:0]         rsp_remainder_o;

    // Requesters drive requests and accept responses.
    modport master (
        output req_valid_i, req_radicand_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_root_o, rsp_remainder_o
    );

    // The scheduler grants requests and presents responses.
    modport slave (
        input  req_valid_i, req_radicand_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_root_o, rsp_remainder_o
    );
endinterface

// File: rtl/sqrt_unit_scheduler.sv
// Shares one iterative sqrt unit among NUM_REQ requesters, round-robin, one op in flight; watchdog + flush.
// Latency: grant in the request cycle; response one cycle after the unit's valid pulse.
// Backpressure: no grant outside IDLE; response held in RESP until the winner's rsp_ready_i.
module sqrt_unit_scheduler #(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = DATA_WIDTH/2 + 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    stall_i,
    sqrt_unit_scheduler_if.slave    req_if,
    output logic                    timeout_o,
    output logic                    sqrt_rst_n_o,
    output logic                    sqrt_clk_en_o,
    output logic [DATA_WIDTH-1:0]   sqrt_radicand_o,
    input  logic [DATA_WIDTH/2-1:0] sqrt_root_i,
    input  logic [DATA_WIDTH/2:0]   sqrt_remainder_i,
    input  logic                    sqrt_valid_i
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        rr_q;
    logic [IDX_W-1:0]        win_q;
    logic [WD_W-1:0]         wd_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH/2-1:0] root_q;
    logic [DATA_WIDTH/2:0]   rem_q;
    logic                    timeout_q;
    logic                    sqrt_rst_n_q;
    logic [DATA_WIDTH-1:0]   radicand_q;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic [NUM_REQ-1:0]      ready_c;
    logic [DATA_WIDTH-1:0]   rad_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rad_arr[g] = req_if.req_radicand_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: scan from the farthest offset back so the nearest valid requester at/after rr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(rr_q) + off) % NUM_REQ);
            if (req_if.req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Grant is only offered in IDLE and is suppressed by a flush in the same cycle.
    always_comb begin
        ready_c = '0;
        if (state_q == IDLE && grant_vld && !flush_i) begin
            ready_c[grant_idx] = 1'b1;
        end
    end

    // Scheduler FSM: launch the unit on grant, wait for valid/flush/watchdog, then hold the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            win_q        <= '0;
            wd_q         <= '0;
            rsp_valid_q  <= '0;
            root_q       <= '0;
            rem_q        <= '0;
            timeout_q    <= 1'b0;
            sqrt_rst_n_q <= 1'b0;
            radicand_q   <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld && !flush_i) begin
                        radicand_q   <= rad_arr[grant_idx];
                        win_q        <= grant_idx;
                        sqrt_rst_n_q <= 1'b1;
                        wd_q         <= '0;
                        rr_q         <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // Flush beats both a same-cycle result and a watchdog expiry.
                    if (flush_i) begin
                        sqrt_rst_n_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (!stall_i) begin
                        wd_q <= wd_q + 1'b1;
                        if (sqrt_valid_i) begin
                            root_q              <= sqrt_root_i;
                            rem_q               <= sqrt_remainder_i;
                            sqrt_rst_n_q        <= 1'b0;
                            rsp_valid_q[win_q]  <= 1'b1;
                            state_q             <= RESP;
                        end else if (wd_q == WD_LAST) begin
                            timeout_q    <= 1'b1;
                            sqrt_rst_n_q <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (flush_i || req_if.rsp_ready_i[win_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.req_ready_o     = ready_c;
    assign req_if.rsp_valid_o     = rsp_valid_q;
    assign req_if.rsp_root_o      = root_q;
    assign req_if.rsp_remainder_o = rem_q;
    assign timeout_o              = timeout_q;
    assign sqrt_rst_n_o           = sqrt_rst_n_q;
    assign sqrt_clk_en_o          = ~stall_i;
    assign sqrt_radicand_o        = radicand_q;
endmodule

// File: tb/tb_sqrt_unit_scheduler.sv
// Bench for the shared sqrt scheduler with a behavioural sqrt unit and an arbitration/result model.
// Latency: expects response visible unit latency + 1 cycle after grant, plus one per stalled cycle.
// Backpressure: holds rsp_ready_i low and checks the response and the grant path stay frozen.
module tb_sqrt_unit_scheduler;
    localparam int DW = 48;
    localparam int NR = 2;
    localparam int TO = DW/2 + 8;

    logic          clk_i;
    logic          rst_i;
    logic          flush_i;
    logic          stall_i;
    logic          timeout_o;
    logic          sqrt_rst_n_o;
    logic          sqrt_clk_en_o;
    logic [DW-1:0] sqrt_radicand_o;
    logic [DW/2-1:0] sqrt_root_i;
    logic [DW/2:0]   sqrt_remainder_i;
    logic          sqrt_valid_i = 1'b0;

    sqrt_unit_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    sqrt_unit_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .stall_i          (stall_i),
        .req_if           (bus),
        .timeout_o        (timeout_o),
        .sqrt_rst_n_o     (sqrt_rst_n_o),
        .sqrt_clk_en_o    (sqrt_clk_en_o),
        .sqrt_radicand_o  (sqrt_radicand_o),
        .sqrt_root_i      (sqrt_root_i),
        .sqrt_remainder_i (sqrt_remainder_i),
        .sqrt_valid_i     (sqrt_valid_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;

    // Integer square root by binary search; roots of 48-bit values are below 2^24.
    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'd1 << 24;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Behavioural sqrt unit: result is a pure function of the radicand, valid pulses after unit_lat enabled cycles.
    int unsigned     unit_lat   = 1;
    bit              unit_never = 1'b0;
    int unsigned     unit_cnt   = 0;
    longint unsigned m_root;

    always_comb begin
        m_root           = isqrt(64'(sqrt_radicand_o));
        sqrt_root_i      = 24'(m_root);
        sqrt_remainder_i = 25'(64'(sqrt_radicand_o) - m_root * m_root);
    end

    always @(posedge clk_i) begin
        if (!sqrt_rst_n_o) begin
            unit_cnt     <= 0;
            sqrt_valid_i <= 1'b0;
        end else if (sqrt_clk_en_o) begin
            unit_cnt     <= unit_cnt + 1;
            sqrt_valid_i <= !unit_never && (unit_cnt == unit_lat - 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First valid requester at or after the model's round-robin pointer.
    function automatic int pick(input logic [NR-1:0] v);
        int k;
        for (int off = 0; off < NR; off++) begin
            k = (rr_m + off) % NR;
            if (|(v & (NR'(1) << k))) return k;
        end
        return -1;
    endfunction

    // One complete transaction; must be entered at a falling edge with the scheduler idle, returns likewise.
    task automatic run_txn(input logic [NR-1:0] vld, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                           input int lat, input int hold, input bit keep, input bit rnd_stall,
                           output int won, output logic [DW/2-1:0] got_root, output logic [DW/2:0] got_rem);
        int n;
        int stalls;
        logic [DW-1:0] rad;
        longint unsigned er;
        unit_lat   = lat;
        unit_never = 1'b0;
        bus.req_valid_i    = vld;
        bus.req_radicand_i = {r1, r0};
        #1;
        won = pick(vld);
        rad = (won == 1) ? r1 : r0;
        chk("grant", 64'(bus.req_ready_o), 64'(1) << won);
        rr_m = (won + 1) % NR;
        @(negedge clk_i);
        if (!keep) bus.req_valid_i = '0;
        chk("busy_no_grant", 64'(bus.req_ready_o), 64'(0));
        chk("unit_released", 64'(sqrt_rst_n_o), 64'(1));
        chk("radicand_out", 64'(sqrt_radicand_o), 64'(rad));
        n = 1;
        stalls = 0;
        while (bus.rsp_valid_o == '0 && n < 200) begin
            stall_i = rnd_stall && ($urandom_range(0, 3) == 0);
            if (stall_i) stalls++;
            @(negedge clk_i);
            n++;
        end
        stall_i = 1'b0;
        chk("rsp_latency", 64'(n), 64'(lat + 2 + stalls));
        er = isqrt(64'(rad));
        chk("rsp_onehot", 64'(bus.rsp_valid_o), 64'(1) << won);
        chk("rsp_root", 64'(bus.rsp_root_o), er);
        chk("rsp_rem", 64'(bus.rsp_remainder_o), 64'(rad) - er * er);
        chk("unit_rereset", 64'(sqrt_rst_n_o), 64'(0));
        got_root = bus.rsp_root_o;
        got_rem  = bus.rsp_remainder_o;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready_i = ~(NR'(1) << won);
            @(negedge clk_i);
            chk("bp_valid", 64'(bus.rsp_valid_o), 64'(1) << won);
            chk("bp_root", 64'(bus.rsp_root_o), er);
            chk("bp_rem", 64'(bus.rsp_remainder_o), 64'(rad) - er * er);
            chk("bp_no_grant", 64'(bus.req_ready_o), 64'(0));
        end
        bus.rsp_ready_i = NR'(1) << won;
        @(negedge clk_i);
        bus.rsp_ready_i = '0;
        chk("rsp_done", 64'(bus.rsp_valid_o), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int w;
        int n;
        int stalls;
        logic [DW/2-1:0] root;
        logic [DW/2:0]   rem;
        logic [DW-1:0]   a0;
        logic [DW-1:0]   a1;

        rst_i = 1'b1;
        flush_i = 1'b0;
        stall_i = 1'b0;
        bus.req_valid_i = '0;
        bus.req_radicand_i = '0;
        bus.rsp_ready_i = '0;
        #12;
        chk("rst_unit_rst_n", 64'(sqrt_rst_n_o), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
        chk("rst_radicand", 64'(sqrt_radicand_o), 64'(0));
        chk("rst_root", 64'(bus.rsp_root_o), 64'(0));
        chk("rst_rem", 64'(bus.rsp_remainder_o), 64'(0));
        chk("rst_clk_en", 64'(sqrt_clk_en_o), 64'(1));
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single op: 144 -> 12 rem 0
        run_txn(2'b01, 48'd144, 48'd0, 3, 0, 1'b0, 1'b0, w, root, rem);
        chk("t1_root", 64'(root), 64'd12);
        chk("t1_rem", 64'(rem), 64'd0);

        // Contention: realign pointer to 0, then both valid continuously must alternate 0,1,0,1
        run_txn(2'b10, 48'd81, 48'd81, 2, 0, 1'b0, 1'b0, w, root, rem);
        chk("t2_pre_winner", 64'(w), 64'd1);
        for (int i = 0; i < 4; i++) begin
            a0 = 48'({$urandom(), $urandom()});
            a1 = 48'({$urandom(), $urandom()});
            run_txn(2'b11, a0, a1, int'($urandom_range(1, 8)), 0, 1'b1, 1'b0, w, root, rem);
            chk("t2_alternate", 64'(w), 64'(i % 2));
        end

        // Backpressure: response frozen for 10 cycles with another requester pending
        run_txn(2'b11, 48'd1000000, 48'd99, 5, 10, 1'b1, 1'b0, w, root, rem);
        bus.req_valid_i = '0;

        // Flush on the same cycle as the unit's valid; the queued request is granted right after
        unit_lat = 4;
        bus.req_radicand_i = {48'd50, 48'd1000};
        bus.req_valid_i = 2'b01;
        #1;
        w = pick(2'b01);
        chk("t4_grant", 64'(bus.req_ready_o), 64'(1) << w);
        rr_m = (w + 1) % NR;
        @(negedge clk_i);
        bus.req_valid_i = 2'b10;
        n = 0;
        while (sqrt_valid_i !== 1'b1 && n < 50) begin
            chk("t4_no_rsp_busy", 64'(bus.rsp_valid_o), 64'(0));
            @(negedge clk_i);
            n++;
        end
        chk("t4_saw_valid", 64'(sqrt_valid_i), 64'(1));
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        chk("t4_flush_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
        chk("t4_flush_rereset", 64'(sqrt_rst_n_o), 64'(0));
        chk("t4_queued_grant", 64'(bus.req_ready_o), 64'b10);
        run_txn(2'b10, 48'd1000, 48'd50, 4, 0, 1'b0, 1'b0, w, root, rem);
        chk("t4_queued_root", 64'(root), 64'd7);

        // Watchdog: unit never answers; three stalled cycles extend the deadline by three
        unit_never = 1'b1;
        bus.req_radicand_i = {48'd0, 48'd12345};
        bus.req_valid_i = 2'b01;
        #1;
        w = pick(2'b01);
        chk("t5_grant", 64'(bus.req_ready_o), 64'(1) << w);
        rr_m = (w + 1) % NR;
        @(negedge clk_i);
        bus.req_valid_i = '0;
        n = 1;
        stalls = 0;
        while (timeout_o !== 1'b1 && n < 200) begin
            stall_i = (n >= 3 && n <= 5);
            if (stall_i) stalls++;
            @(negedge clk_i);
            n++;
        end
        stall_i = 1'b0;
        chk("t5_timeout_at", 64'(n), 64'(TO + 1 + stalls));
        chk("t5_rereset", 64'(sqrt_rst_n_o), 64'(0));
        chk("t5_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
        @(negedge clk_i);
        chk("t5_pulse_one_cycle", 64'(timeout_o), 64'(0));
        unit_never = 1'b0;

        // Full-scale radicand
        run_txn(2'b01, 48'hFFFF_FFFF_FFFF, 48'd0, 20, 2, 1'b0, 1'b0, w, root, rem);
        chk("t6_root", 64'(root), 64'hFF_FFFF);
        chk("t6_rem", 64'(rem), 64'h1FF_FFFE);

        // Asynchronous reset in the middle of BUSY
        unit_lat = 10;
        bus.req_radicand_i = {48'd777, 48'd0};
        bus.req_valid_i = 2'b10;
        #1;
        w = pick(2'b10);
        chk("t6_busy_grant", 64'(bus.req_ready_o), 64'(1) << w);
        @(negedge clk_i);
        bus.req_valid_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_unit_rst_n", 64'(sqrt_rst_n_o), 64'(0));
        chk("t6_rst_radicand", 64'(sqrt_radicand_o), 64'(0));
        chk("t6_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("t6_rst_root", 64'(bus.rsp_root_o), 64'(0));
        chk("t6_rst_timeout", 64'(timeout_o), 64'(0));
        rr_m = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Randomised traffic with random stalls and backpressure
        for (int i = 0; i < 16; i++) begin
            a0 = 48'({$urandom(), $urandom()});
            a1 = 48'({$urandom(), $urandom()});
            run_txn(NR'($urandom_range(1, 3)), a0, a1, int'($urandom_range(1, 24)),
                    int'($urandom_range(0, 3)), 1'b0, 1'b1, w, root, rem);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
